// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, issues word requests, queues responses for decode.
// Optional FETCH_ALIGN_CHECK_EN: a misaligned redirect yields one faulting NOP entry, then stalls.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        insn_valid,
  output logic [31:0] insn,
  output logic [31:0] insn_pc,
  input  logic        insn_ready
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        insn_fault
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc_reg;
  logic          started_reg;
  logic [CW-1:0] live_reg;
  logic [CW-1:0] stale_reg;
  logic [CW-1:0] occ_reg;
  logic [AW-1:0] q_rd_reg;
  logic [AW-1:0] q_wr_reg;
  logic [AW-1:0] pf_rd_reg;
  logic [AW-1:0] pf_wr_reg;
  logic [31:0]   q_insn [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   pf_pc  [DEPTH];

  logic [CW+1:0] inflight;
  logic          grant;
  logic          rsp_stale;
  logic          rsp_live;
  logic          rsp_any;
  logic          pop;
  logic          push;
  logic          run_ok;
  logic          fault_push;
  logic [31:0]   push_insn;
  logic [31:0]   push_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {S_RUN, S_FAULT_WAIT, S_FAULT_HOLD} state_t;
  state_t      state_reg;
  logic [31:0] fault_pc_reg;
  logic        q_fault [DEPTH];
  logic        misaligned;

  assign misaligned = redirect_pc[1:0] != 2'b00;
  assign run_ok     = state_reg == S_RUN;
  // The fault entry waits until every stale response has drained.
  assign fault_push = (state_reg == S_FAULT_WAIT) && (stale_reg == '0) && !redirect;
  assign push_insn  = fault_push ? NOP : imem_rdata;
  assign push_pc    = fault_push ? fault_pc_reg : pf_pc[pf_rd_reg];
  assign insn_fault = q_fault[q_rd_reg];
`else
  logic unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];
  assign run_ok         = 1'b1;
  assign fault_push     = 1'b0;
  assign push_insn      = imem_rdata;
  assign push_pc        = pf_pc[pf_rd_reg];
`endif

  // Every outstanding request, stale or live, reserves a queue slot.
  assign inflight   = {2'b00, live_reg} + {2'b00, stale_reg} + {2'b00, occ_reg};
  assign imem_req   = started_reg && !redirect && run_ok && (inflight < (CW+2)'(DEPTH));
  assign imem_addr  = pc_reg;
  assign grant      = imem_req && imem_gnt;
  assign rsp_stale  = imem_rvalid && (stale_reg != '0);
  assign rsp_live   = imem_rvalid && (stale_reg == '0) && (live_reg != '0);
  assign rsp_any    = rsp_stale || rsp_live;
  assign insn_valid = occ_reg != '0;
  assign pop        = insn_valid && insn_ready;
  assign push       = rsp_live || fault_push;
  assign insn       = q_insn[q_rd_reg];
  assign insn_pc    = q_pc[q_rd_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg      <= RESET_PC;
      started_reg <= 1'b0;
      live_reg    <= '0;
      stale_reg   <= '0;
      occ_reg     <= '0;
      q_rd_reg    <= '0;
      q_wr_reg    <= '0;
      pf_rd_reg   <= '0;
      pf_wr_reg   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_insn[i] <= '0;
        q_pc[i]   <= '0;
        pf_pc[i]  <= '0;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      state_reg    <= S_RUN;
      fault_pc_reg <= '0;
      for (int i = 0; i < DEPTH; i++) q_fault[i] <= 1'b0;
`endif
    end else begin
      started_reg <= 1'b1;
      if (redirect) begin
        // All outstanding requests become stale; a response arriving now retires one of them.
        stale_reg <= stale_reg + live_reg - CW'(rsp_any);
        live_reg  <= '0;
        occ_reg   <= '0;
        q_rd_reg  <= '0;
        q_wr_reg  <= '0;
        pf_rd_reg <= '0;
        pf_wr_reg <= '0;
        pc_reg    <= {redirect_pc[31:2], 2'b00};
`ifdef FETCH_ALIGN_CHECK_EN
        state_reg    <= misaligned ? S_FAULT_WAIT : S_RUN;
        fault_pc_reg <= redirect_pc;
`endif
      end else begin
        if (grant) begin
          pc_reg           <= pc_reg + 32'd4;
          pf_pc[pf_wr_reg] <= pc_reg;
          pf_wr_reg        <= pf_wr_reg + AW'(1);
        end
        live_reg <= live_reg + CW'(grant) - CW'(rsp_live);
        if (rsp_stale) stale_reg <= stale_reg - CW'(1);
        if (rsp_live) pf_rd_reg <= pf_rd_reg + AW'(1);
        if (push) begin
          q_insn[q_wr_reg] <= push_insn;
          q_pc[q_wr_reg]   <= push_pc;
          q_wr_reg         <= q_wr_reg + AW'(1);
        end
        if (pop) q_rd_reg <= q_rd_reg + AW'(1);
        occ_reg <= occ_reg + CW'(push) - CW'(pop);
`ifdef FETCH_ALIGN_CHECK_EN
        if (push) q_fault[q_wr_reg] <= fault_push;
        if (fault_push) state_reg <= S_FAULT_HOLD;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: bus responder plus scoreboard of expected {pc, word} in delivery order.
// Build with FETCH_ALIGN_CHECK_EN defined to exercise the misaligned-redirect fault path.
module tb_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        insn_valid;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        insn_ready = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        insn_fault;
  logic        fault_mode = 1'b0;
`endif

  always #5 clk = ~clk;

  fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .insn_valid(insn_valid), .insn(insn), .insn_pc(insn_pc), .insn_ready(insn_ready)
`ifdef FETCH_ALIGN_CHECK_EN
    , .insn_fault(insn_fault)
`endif
  );

  typedef struct { logic [31:0] pc; logic [31:0] word; logic fault; } exp_t;
  typedef struct { logic [31:0] rpc; int ncyc; int gpct; int rpct; int ypct; logic [31:0] exp_first; } row_t;

  exp_t        sb[$];
  logic [31:0] pend[$];
  int          total = 0, bad = 0;
  int          gnt_pct = 0, rv_pct = 0;
  int          grants = 0, delivered = 0, d0 = 0;
  logic [31:0] fetch_model = RESET_PC;
  logic        first_seen = 1'b0;
  logic [31:0] first_pc = '0;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc;
  row_t        tab[4];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive_rsp();
    if (pend.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  endtask

  // One bus cycle: sample and score at the falling edge, drive next inputs just after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    s_req = imem_req; s_addr = imem_addr; s_valid = insn_valid; s_pc = insn_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    if (fault_mode && !redirect) check("req_in_fault", 32'(imem_req), 32'd0);
`endif
    if (redirect) begin
      check("req_in_redirect", 32'(imem_req), 32'd0);
      sb.delete();
      fetch_model = {redirect_pc[31:2], 2'b00};
      first_seen  = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_mode = redirect_pc[1:0] != 2'b00;
      if (fault_mode) sb.push_back('{redirect_pc, 32'h0000_0013, 1'b1});
`endif
    end else if (imem_req && imem_gnt) begin
      check("grant_addr", imem_addr, fetch_model);
      sb.push_back('{fetch_model, mem_word(fetch_model), 1'b0});
      pend.push_back(imem_addr);
      $display("grant addr=%h", imem_addr);
      fetch_model = fetch_model + 32'd4;
      grants++;
    end
    if (imem_rvalid && pend.size() > 0) void'(pend.pop_front());
    if (insn_valid && insn_ready && !redirect) begin
      $display("deliver pc=%h insn=%h", insn_pc, insn);
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_insn: got pc=%h want none", insn_pc);
      end else begin
        e = sb.pop_front();
        check("insn_pc", insn_pc, e.pc);
        check("insn", insn, e.word);
`ifdef FETCH_ALIGN_CHECK_EN
        check("insn_fault", 32'(insn_fault), 32'(e.fault));
`endif
        if (!first_seen) begin
          first_seen = 1'b1;
          first_pc   = insn_pc;
        end
        delivered++;
      end
    end
    @(posedge clk);
    #1;
    redirect = 1'b0;
    imem_gnt = $urandom_range(0, 99) < gnt_pct;
    if ($urandom_range(0, 99) < rv_pct) drive_rsp();
    else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  endtask

  // Asserts reset mid-cycle, checks outputs follow immediately, releases just after a rising edge.
  task automatic reset_dut();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", 32'(insn_valid), 32'd0);
    check("rst_insn", insn, 32'd0);
    check("rst_insn_pc", insn_pc, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    check("rst_fault", 32'(insn_fault), 32'd0);
    fault_mode = 1'b0;
`endif
    pend.delete();
    sb.delete();
    fetch_model = RESET_PC;
    first_seen = 1'b0;
    redirect = 1'b0; insn_ready = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    grants = 0; delivered = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want test done");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0] = '{32'h0000_1000, 60, 100, 100, 100, 32'h0000_1000};
    tab[1] = '{32'h0000_2000, 80,  60,  50,  70, 32'h0000_2000};
    tab[2] = '{32'hFFFF_FFF0, 60,  80,  80,  40, 32'hFFFF_FFF0};
    tab[3] = '{32'h0000_0300, 80,  30,  90,  90, 32'h0000_0300};

    // Startup latency and streaming
    reset_dut();
    gnt_pct = 100; rv_pct = 100; insn_ready = 1'b1;
    cycle(); check("req_cycle0", 32'(s_req), 32'd0);
    cycle(); check("req_cycle1", 32'(s_req), 32'd1); check("addr_cycle1", s_addr, RESET_PC);
    cycle(); check("valid_gnt_plus1", 32'(s_valid), 32'd0);
    cycle(); check("valid_gnt_plus2", 32'(s_valid), 32'd1); check("first_pc", s_pc, RESET_PC);
    repeat (20) cycle();
    check("stream_rate", 32'(delivered >= 10), 32'd1);

    // Decode stalled: credits cap outstanding work at DEPTH
    reset_dut();
    gnt_pct = 100; rv_pct = 100; insn_ready = 1'b0;
    repeat (8) cycle();
    check("stall_grants", 32'(grants), 32'd2);
    check("stall_req", 32'(s_req), 32'd0);
    check("stall_valid", 32'(s_valid), 32'd1);
    check("stall_head", s_pc, RESET_PC);
    insn_ready = 1'b1; cycle();
    insn_ready = 1'b0; cycle();
    check("req_after_pop", 32'(s_req), 32'd1);
    check("addr_after_pop", s_addr, 32'h0000_0008);
    insn_ready = 1'b1; repeat (10) cycle();

    // Redirect with two requests in flight
    reset_dut();
    gnt_pct = 100; rv_pct = 0; insn_ready = 1'b1;
    repeat (4) cycle();
    check("inflight_grants", 32'(grants), 32'd2);
    redirect = 1'b1; redirect_pc = 32'h0000_0100; rv_pct = 100;
    cycle();
    repeat (12) cycle();
    check("redir_seen", 32'(first_seen), 32'd1);
    check("redir_first_pc", first_pc, 32'h0000_0100);

    // Redirect coinciding with a pop and a response
    reset_dut();
    gnt_pct = 100; rv_pct = 0; insn_ready = 1'b0;
    repeat (4) cycle();
    gnt_pct = 0; imem_gnt = 1'b0; drive_rsp();
    cycle();
    drive_rsp();
    redirect = 1'b1; redirect_pc = 32'h0000_0200; insn_ready = 1'b1;
    gnt_pct = 100; rv_pct = 100; imem_gnt = 1'b0;
    cycle(); check("redir_cycle_valid", 32'(s_valid), 32'd1);
    cycle(); check("flush_valid", 32'(s_valid), 32'd0);
    repeat (12) cycle();
    check("flush_seen", 32'(first_seen), 32'd1);
    check("flush_first_pc", first_pc, 32'h0000_0200);

    // Reset mid-stream with one response outstanding
    gnt_pct = 0; imem_gnt = 1'b0; rv_pct = 100; insn_ready = 1'b1;
    repeat (6) cycle();
    redirect = 1'b1; redirect_pc = 32'h0000_0040; insn_ready = 1'b0; gnt_pct = 100; rv_pct = 0;
    cycle();
    repeat (3) cycle();
    gnt_pct = 0; imem_gnt = 1'b0; drive_rsp();
    cycle();
    cycle();
    check("pre_reset_valid", 32'(s_valid), 32'd1);
    check("pre_reset_pc", s_pc, 32'h0000_0040);
    reset_dut();
    gnt_pct = 100; rv_pct = 100; insn_ready = 1'b1;
    repeat (12) cycle();
    check("restart_first_pc", first_pc, RESET_PC);

    // Randomised traffic phases from the table
    for (int r = 0; r < 4; r++) begin
      redirect = 1'b1; redirect_pc = tab[r].rpc;
      gnt_pct = tab[r].gpct; rv_pct = tab[r].rpct;
      cycle();
      for (int c = 0; c < tab[r].ncyc; c++) begin
        insn_ready = $urandom_range(0, 99) < tab[r].ypct;
        cycle();
      end
      gnt_pct = 0; imem_gnt = 1'b0; rv_pct = 100; insn_ready = 1'b1;
      repeat (10) cycle();
      check("row_seen", 32'(first_seen), 32'd1);
      check("row_first_pc", first_pc, tab[r].exp_first);
      check("row_drained", 32'(sb.size()), 32'd0);
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect with stale responses pending
    redirect = 1'b1; redirect_pc = 32'h0000_0500; gnt_pct = 100; rv_pct = 0; insn_ready = 1'b0;
    cycle();
    repeat (3) cycle();
    redirect = 1'b1; redirect_pc = 32'h0000_0102; rv_pct = 100; insn_ready = 1'b1;
    d0 = delivered;
    cycle();
    repeat (10) cycle();
    check("fault_count", 32'(delivered - d0), 32'd1);
    check("fault_first_pc", first_pc, 32'h0000_0102);
    check("fault_hold_req", 32'(s_req), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    cycle();
    repeat (10) cycle();
    check("resume_seen", 32'(first_seen), 32'd1);
    check("resume_first_pc", first_pc, 32'h0000_0200);
`else
    // Misaligned redirect target is silently aligned
    redirect = 1'b1; redirect_pc = 32'h0000_0106; gnt_pct = 100; rv_pct = 100; insn_ready = 1'b1;
    cycle();
    repeat (10) cycle();
    check("align_seen", 32'(first_seen), 32'd1);
    check("align_first_pc", first_pc, 32'h0000_0104);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
